rr_client_arbiter: RTL and testbench
====================================

Name: rr_client_arbiter

Overview:
- Round-robin arbiter that shares one resource between NUM_CLIENTS requesters.
- Produces a registered one-hot grant vector plus the matching binary index, so downstream muxes can use either the one-hot or the encoded select.
- Sits in front of the shared datapath: clients raise req, the owner holds the grant until it signals done.
- The grant lasts multiple cycles (lock-style); it is not a per-cycle grant.

Parameters:
- NUM_CLIENTS, 16, number of requesters; legal range 2..4096; need not be a power of two.
- IDX_W, $clog2(NUM_CLIENTS), width of the binary grant index; derived, not to be overridden.
- MAX_HOLD, 256, maximum cycles one client may own the resource; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_CLIENTS  per-client request, level-sensitive.
- done  input  1  release strobe from the current owner; one cycle.
- gnt  output  NUM_CLIENTS  registered one-hot grant; all zero when idle.
- gnt_idx  output  IDX_W  binary index of the granted client; valid while gnt_valid=1.
- gnt_valid  output  1  high while any grant is held; equals |gnt.
- timeout  output  1  one-cycle pulse on forced release; tied 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset, sampled on clk while rst=1:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - Reset overrides everything, including mid-grant: the grant drops on the cycle after rst is sampled.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching ptr, ptr+1, ..., NUM_CLIENTS-1, 0, ..., ptr-1.
  - Register gnt=1<<i, gnt_idx=i, gnt_valid=1, and go to GRANT.
  - Latency: req sampled in cycle t gives the grant visible in cycle t+1.
- State GRANT:
  - gnt, gnt_idx and gnt_valid stay stable while done=0 and req[gnt_idx]=1.
  - Release condition: done=1, or the owner drops req[gnt_idx].
  - On release, the next cycle has gnt=0 and gnt_valid=0, gnt_idx keeps its last value, ptr=gnt_idx+1 with wrap from NUM_CLIENTS-1 to 0, and state=IDLE.
  - There is always one idle cycle between consecutive grants; no back-to-back grants.
  - done while in IDLE is ignored.
  - done together with the owner's req still high: release wins; the owner may be regranted later only through round-robin order.
  - Requests from non-owners during GRANT are only observed; they do not preempt.
- Fairness: a client that keeps req high is granted within NUM_CLIENTS arbitration rounds.
- Width rules:
  - gnt_idx is always < NUM_CLIENTS.
  - The ptr increment compares against NUM_CLIENTS-1 explicitly; it does not rely on IDX_W overflow, so non-power-of-two counts work.
- Invariant: gnt is always one-hot or zero, and gnt[gnt_idx]==gnt_valid.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An IDX-independent hold counter of $clog2(MAX_HOLD+1) bits clears on grant and increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 with no release, the next cycle forces a release (same effect as done).
  - timeout=1 for exactly that cycle.
  - If done arrives in the same cycle as the limit, it is a normal release with timeout=0.
- Undefined: no counter is built, timeout is constant 0, and ownership is unbounded.

Test Plan (NUM_CLIENTS=4, MAX_HOLD=8 unless stated):
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_idx=0 throughout; the first grant after release of reset is gnt=4'b0001, one cycle after rst falls.
- Rotation: req=4'b1111 held, done pulsed 2 cycles after each grant -> grant order 0,1,2,3,0; gnt_valid=0 for exactly one cycle between grants.
- Pointer skip and wrap: ptr=3 after client 2 is released, req=4'b0101 -> gnt=4'b0001, gnt_idx=0 (search wraps past 3); the next grant is gnt=4'b0100, gnt_idx=2.
- Drop request: client 1 owns the grant and req[1] falls while done=0 -> gnt=0 the next cycle, ptr=2, timeout=0.
- Mid-operation reset: client 2 owns the grant and rst is asserted for 1 cycle -> gnt=0 the next cycle; after reset with req=4'b0100, grant goes to client 2 via ptr=0.
- ARB_TIMEOUT_EN: client 0 holds req with no done -> 8 grant cycles, then gnt=0 with timeout=1 for one cycle, and client 1 (req high) is granted next. With done asserted on the 8th cycle -> timeout stays 0.

Source files
------------

// File: rtl/rr_client_arbiter.sv
// rr_client_arbiter: lock-style round-robin arbiter sharing one resource among NUM_CLIENTS requesters.
// Latency: a request sampled in cycle t is granted in cycle t+1; at least one idle cycle separates grants.
// Backpressure: the owner keeps the grant until it pulses done or drops its request; other clients wait.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   req        per-client level request
//   done       one-cycle release strobe from the current owner
//   gnt        registered one-hot grant, zero when idle
//   gnt_idx    binary index of the granted client (holds last value while idle)
//   gnt_valid  high while a grant is held (equals |gnt)
//   timeout    one-cycle pulse on a forced release
//
// Optional feature, macro ARB_TIMEOUT_EN: bounds ownership to MAX_HOLD cycles and drives timeout.
// Without the macro no hold counter exists and timeout is constant 0.
module rr_client_arbiter #(
   parameter int NUM_CLIENTS = 16,
   parameter int IDX_W       = $clog2(NUM_CLIENTS),
   parameter int MAX_HOLD    = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic                   done,
   output logic [NUM_CLIENTS-1:0] gnt,
   output logic [IDX_W-1:0]       gnt_idx,
   output logic                   gnt_valid,
   output logic                   timeout
);

   if (NUM_CLIENTS < 2 || MAX_HOLD < 1 || IDX_W != $clog2(NUM_CLIENTS)) begin : g_param_check
      $error("rr_client_arbiter: illegal parameter combination");
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       ptr, ptr_nxt;
   logic [IDX_W-1:0]       idx_nxt;
   logic [NUM_CLIENTS-1:0] gnt_nxt;
   logic [IDX_W-1:0]       sel;
   logic                   found;
   logic [IDX_W:0]         cand;
   logic                   owner_req;
   logic                   at_limit;

   assign owner_req = req[gnt_idx];
   assign gnt_valid = (state == GRANT);

   // Search ptr, ptr+1, ... with wrap. cand is one bit wider than an index so
   // ptr+k never overflows; a single subtraction brings it back into range,
   // which keeps non-power-of-two client counts correct.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_CLIENTS))
            cand = cand - (IDX_W+1)'(NUM_CLIENTS);
         if (!found && req[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            sel   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = gnt_idx;
      gnt_nxt   = gnt;
      case (state)
         IDLE: begin
            // done while idle is ignored
            if (found) begin
               gnt_nxt      = '0;
               gnt_nxt[sel] = 1'b1;
               idx_nxt      = sel;
               state_nxt    = GRANT;
            end
         end
         GRANT: begin
            if (done || !owner_req || at_limit) begin
               gnt_nxt   = '0;
               state_nxt = IDLE;
               ptr_nxt   = (gnt_idx == IDX_W'(NUM_CLIENTS-1)) ? '0 : gnt_idx + IDX_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         gnt     <= gnt_nxt;
         gnt_idx <= idx_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD+1);

   logic [HOLD_W-1:0] hold_cnt, hold_nxt;

   // hold_cnt is 0 in the first grant cycle, so reaching MAX_HOLD-1 means
   // the owner has had MAX_HOLD cycles and must let go at this edge.
   assign at_limit = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD-1));

   always_comb begin
      hold_nxt = (state == GRANT) ? hold_cnt + HOLD_W'(1) : '0;
   end

   // A release that done or a dropped request would cause anyway is normal,
   // so timeout flags only releases forced purely by the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         hold_cnt <= hold_nxt;
         timeout  <= at_limit && !done && owner_req;
      end
   end
`else
   assign at_limit = 1'b0;
   assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rr_client_arbiter.sv
// tb_rr_client_arbiter: self-checking bench for rr_client_arbiter with NUM_CLIENTS=4, MAX_HOLD=8.
// Latency: compares DUT outputs 1 time unit after every rising edge against a cycle model.
// Backpressure: not applicable; the bench drives req/done/rst directly.
module tb_rr_client_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int MH = 8;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic          done;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          gnt_valid;
   logic          timeout;
   logic [N+IW+1:0] dut_vec;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owner is the granted client or -1, ptr is where the
   // next search starts, hold counts grant cycles seen so far.
   int owner  = -1;
   int m_ptr  = 0;
   int m_last = 0;
   int m_hold = 0;
   bit m_to   = 1'b0;

   always #5 clk = ~clk;

   assign dut_vec = {gnt, gnt_idx, gnt_valid, timeout};

   rr_client_arbiter #(.NUM_CLIENTS(N), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
   );

   function automatic logic [N+IW+1:0] exp_vec();
      logic [N-1:0] g;
      g = '0;
      if (owner >= 0) g[owner] = 1'b1;
      return {g, IW'(m_last), (owner >= 0), m_to};
   endfunction

   // Advance one clock and update the model from the inputs sampled at that edge.
   task automatic tick();
      bit rel, lim;
      @(posedge clk);
      if (rst) begin
         owner = -1; m_ptr = 0; m_last = 0; m_hold = 0; m_to = 1'b0;
      end else if (owner < 0) begin
         m_to = 1'b0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (owner < 0 && req[c]) begin
               owner = c; m_last = c; m_hold = 1;
            end
         end
      end else begin
         rel = done || !req[owner];
         lim = TO_EN && (m_hold == MH);
         if (rel || lim) begin
            m_to  = lim && !rel;
            m_ptr = (owner + 1) % N;
            owner = -1;
         end else begin
            m_hold++;
            m_to = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (dut_vec !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: got %b expected %b", i, dut_vec, {4'b0000, 2'd0, 1'b0, 1'b0});
         end
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (gnt !== 4'b0001 || gnt_valid !== 1'b1 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_first_grant: got %b expected %b", dut_vec, exp_vec());
      end
   endtask

   task automatic test_rotation();
      int order[5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] eg;
      req = 4'b1111; done = 1'b0;
      for (int r = 0; r < 5; r++) begin
         eg = '0; eg[order[r]] = 1'b1;
         n_checks++;
         if (gnt !== eg || gnt_idx !== IW'(order[r]) || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL rotation_grant%0d: got %b expected gnt %b model %b", r, dut_vec, eg, exp_vec());
         end
         tick();
         n_checks++;
         if (gnt !== eg || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL rotation_hold%0d: got %b expected %b", r, dut_vec, exp_vec());
         end
         done = 1'b1;
         tick();
         done = 1'b0;
         n_checks++;
         if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL rotation_idle%0d: got %b expected %b", r, dut_vec, exp_vec());
         end
         if (r < 4) tick();
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_skip_wrap();
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      tick();
      rst = 1'b0; req = 4'b0100;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0; req = 4'b0101;
      tick();
      n_checks++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL skip_wrap_first: got %b expected %b", dut_vec, exp_vec());
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      n_checks++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL skip_wrap_second: got %b expected %b", dut_vec, exp_vec());
      end
      done = 1'b1;
      tick();
      done = 1'b0; req = 4'b0000;
      tick();
   endtask

   task automatic test_drop();
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      tick();
      rst = 1'b0; req = 4'b0010;
      tick();
      tick();
      n_checks++;
      if (gnt !== 4'b0010 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL drop_owner: got %b expected %b", dut_vec, exp_vec());
      end
      req = 4'b0000;
      tick();
      n_checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_idx !== 2'd1 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL drop_release: got %b expected %b", dut_vec, exp_vec());
      end
      req = 4'b1111;
      tick();
      n_checks++;
      if (gnt_idx !== 2'd2 || gnt !== 4'b0100 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL drop_ptr_next: got %b expected %b", dut_vec, exp_vec());
      end
      done = 1'b1;
      tick();
      done = 1'b0; req = 4'b0000;
      tick();
   endtask

   task automatic test_mid_reset();
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      tick();
      rst = 1'b0; req = 4'b0100;
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL mid_reset_drop: got %b expected %b", dut_vec, exp_vec());
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL mid_reset_regrant: got %b expected %b", dut_vec, exp_vec());
      end
      done = 1'b1;
      tick();
      done = 1'b0; req = 4'b1111;
      tick();
      n_checks++;
      if (gnt !== 4'b1000 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL mid_reset_next: got %b expected %b", dut_vec, exp_vec());
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      tick();
`ifdef ARB_TIMEOUT_EN
      rst = 1'b0; req = 4'b0011;
      tick();
      for (int i = 1; i < MH; i++) begin
         tick();
         n_checks++;
         if (gnt !== 4'b0001 || timeout !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL timeout_hold%0d: got %b expected %b", i, dut_vec, exp_vec());
         end
      end
      tick();
      n_checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b1 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL timeout_force: got %b expected %b", dut_vec, exp_vec());
      end
      tick();
      n_checks++;
      if (gnt !== 4'b0010 || timeout !== 1'b0 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL timeout_next_client: got %b expected %b", dut_vec, exp_vec());
      end
      for (int i = 1; i < MH; i++) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL timeout_done_at_limit: got %b expected %b", dut_vec, exp_vec());
      end
`else
      rst = 1'b0; req = 4'b0001;
      tick();
      for (int i = 0; i < 3 * MH; i++) begin
         tick();
         n_checks++;
         if (gnt !== 4'b0001 || timeout !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL unbounded_hold%0d: got %b expected %b", i, dut_vec, exp_vec());
         end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL unbounded_release: got %b expected %b", dut_vec, exp_vec());
      end
`endif
      req = 4'b0000;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(63) == 0);
         if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
         done = ($urandom_range(5) == 0);
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_cyc%0d: got %b expected %b", i, dut_vec, exp_vec());
         end
         n_checks++;
         if ($countones(gnt) > 1 || gnt_valid !== (gnt != 4'b0000) ||
             (gnt_valid && gnt[gnt_idx] !== 1'b1)) begin
            n_fail++;
            $display("FAIL random_invariant%0d: gnt %b idx %0d valid %b", i, gnt, gnt_idx, gnt_valid);
         end
      end
      rst = 1'b0; done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '0; done = 1'b0;
      test_reset();
      test_rotation();
      test_skip_wrap();
      test_drop();
      test_mid_reset();
      test_timeout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
